// File: rtl/vertex_fetch_seq.sv
// vertex_fetch_seq
// Upstream feeder for the vertex transform stage. On a start request it walks a
// synchronous-read vertex memory that holds (x, y, z) triples at consecutive
// word addresses. It presents one assembled vertex at a time under a
// valid/ready handshake. A one-cycle done pulse follows acceptance of the last
// vertex in the frame.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   start, num_vertices   frame request and vertex count (sampled in IDLE only)
//   mem_rd_en, mem_addr   read strobe and word address to the vertex memory
//   mem_rd_data           read data, valid one cycle after the strobe
//   vertices_1..3         x, y, z of the presented vertex
//   out_valid, out_ready  output handshake
//   vertex_idx            index of the presented vertex within the frame
//   busy, done            activity flag and one-cycle completion pulse
module vertex_fetch_seq #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_vertices,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] vertices_1,
  output logic [DATA_W-1:0] vertices_2,
  output logic [DATA_W-1:0] vertices_3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] vertex_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    F0   = 3'd1,
    F1   = 3'd2,
    F2   = 3'd3,
    F3   = 3'd4,
    HOLD = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [DATA_W-1:0] z_q, z_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;

  // Next-state logic. Each coordinate is captured one state after its read was
  // issued, because the memory returns data one cycle after the request.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_vertices != '0) begin
            count_d = num_vertices;
            addr_d  = '0;
            idx_d   = '0;
            state_d = F0;
          end else begin
            // An empty frame completes immediately without touching memory.
            done_d = 1'b1;
          end
        end
      end
      F0: state_d = F1;
      F1: begin
        x_d     = mem_rd_data;
        state_d = F2;
      end
      F2: begin
        y_d     = mem_rd_data;
        state_d = F3;
      end
      F3: begin
        z_d         = mem_rd_data;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == count_q - ADDR_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            // The base address steps by one triple; it wraps modulo 2^ADDR_W.
            idx_d   = idx_q + ADDR_W'(1);
            addr_d  = addr_q + ADDR_W'(3);
            state_d = F0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      addr_q      <= '0;
      idx_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // The memory interface decodes straight from the registered state so that a
  // read goes out in the same cycle the fetch state is entered. The address
  // is forced to zero whenever no read is in flight.
  always_comb begin
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    unique case (state_q)
      F0: begin
        mem_rd_en = 1'b1;
        mem_addr  = addr_q;
      end
      F1: begin
        mem_rd_en = 1'b1;
        mem_addr  = addr_q + ADDR_W'(1);
      end
      F2: begin
        mem_rd_en = 1'b1;
        mem_addr  = addr_q + ADDR_W'(2);
      end
      default: begin
        mem_rd_en = 1'b0;
        mem_addr  = '0;
      end
    endcase
  end

  assign vertices_1 = x_q;
  assign vertices_2 = y_q;
  assign vertices_3 = z_q;
  assign out_valid  = out_valid_q;
  assign vertex_idx = idx_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule
